// File: rtl/dual_issue_scheduler_pkg.sv
// rtl/dual_issue_scheduler_pkg.sv - no-op encodings, buffer states and pair record for the issue stage
package dual_issue_scheduler_pkg;

    localparam logic [31:0] NOP_EVEN = 32'h40200000;
    localparam logic [31:0] NOP_ODD  = 32'h00200000;

    localparam logic [1:0] ISSUE_EMPTY = 2'd0;
    localparam logic [1:0] ISSUE_FULL  = 2'd1;
    localparam logic [1:0] ISSUE_HALF  = 2'd2;

    typedef struct packed {
        logic [31:0] instr1;
        logic [31:0] instr2;
        logic        pipe1;
        logic        pipe2;
        logic [6:0]  dst1;
        logic        wr1;
        logic [20:0] src2;
        logic [2:0]  src2_v;
    } pair_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// rtl/dual_issue_scheduler_if.sv - fetch pair handshake, hazard controls and issue slots
interface dual_issue_scheduler_if;

    logic        pair_valid;
    logic        pair_ready;
    logic [31:0] pair_instr1;
    logic [31:0] pair_instr2;
    logic        pair_pipe1;
    logic        pair_pipe2;
    logic [6:0]  pair_dst1;
    logic        pair_wr1;
    logic [20:0] pair_src2;
    logic [2:0]  pair_src2_v;
    logic        stall;
    logic        flush;
    logic [31:0] issue_even_instr;
    logic [31:0] issue_odd_instr;
    logic        issue_even_valid;
    logic        issue_odd_valid;

    modport master (
        output pair_valid, pair_instr1, pair_instr2, pair_pipe1, pair_pipe2,
               pair_dst1, pair_wr1, pair_src2, pair_src2_v, stall, flush,
        input  pair_ready, issue_even_instr, issue_odd_instr,
               issue_even_valid, issue_odd_valid
    );

    modport slave (
        input  pair_valid, pair_instr1, pair_instr2, pair_pipe1, pair_pipe2,
               pair_dst1, pair_wr1, pair_src2, pair_src2_v, stall, flush,
        output pair_ready, issue_even_instr, issue_odd_instr,
               issue_even_valid, issue_odd_valid
    );

endinterface

// File: rtl/pair_conflict_check.sv
// rtl/pair_conflict_check.sv - flags a pair that must split: same pipe, or instr2 reads instr1's destination
module pair_conflict_check (
    input  logic        pipe1,
    input  logic        pipe2,
    input  logic [6:0]  dst1,
    input  logic        wr1,
    input  logic [20:0] src2,
    input  logic [2:0]  src2_v,
    output logic        conflict
);

    logic [2:0] hit;

    // src2 is {ra, rb, rc}; src2_v bit 2 qualifies ra, bit 0 qualifies rc
    assign hit[2] = src2_v[2] & (src2[20:14] == dst1);
    assign hit[1] = src2_v[1] & (src2[13:7]  == dst1);
    assign hit[0] = src2_v[0] & (src2[6:0]   == dst1);

    assign conflict = (pipe1 == pipe2) | (wr1 & (|hit));

endmodule

// File: rtl/dual_issue_scheduler.sv
// rtl/dual_issue_scheduler.sv - buffers one fetch pair and issues it to even/odd pipes, splitting on conflict
// Optional ISSUE_STATS_EN adds saturating dual/split/stall counters.
module dual_issue_scheduler
    import dual_issue_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    dual_issue_scheduler_if.slave bus
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]           stat_dual,
    output logic [31:0]           stat_split,
    output logic [31:0]           stat_stall
`endif
);

    logic [1:0]  state_q, state_d;
    pair_t       buf_q, pair_in;
    logic        conflict;
    logic        is_empty, is_full, is_half;
    logic        ready, accept, advance;
    logic [31:0] even_d, odd_d, even_q, odd_q;
    logic        even_v_d, odd_v_d, even_v_q, odd_v_q;

    pair_conflict_check u_conflict (
        .pipe1    (buf_q.pipe1),
        .pipe2    (buf_q.pipe2),
        .dst1     (buf_q.dst1),
        .wr1      (buf_q.wr1),
        .src2     (buf_q.src2),
        .src2_v   (buf_q.src2_v),
        .conflict (conflict)
    );

    assign pair_in = '{instr1: bus.pair_instr1, instr2: bus.pair_instr2,
                       pipe1: bus.pair_pipe1, pipe2: bus.pair_pipe2,
                       dst1: bus.pair_dst1, wr1: bus.pair_wr1,
                       src2: bus.pair_src2, src2_v: bus.pair_src2_v};

    assign is_empty = (state_q == ISSUE_EMPTY);
    assign is_full  = (state_q == ISSUE_FULL);
    assign is_half  = (state_q == ISSUE_HALF);
    assign advance  = !bus.flush && !bus.stall;
    assign ready    = !bus.flush && (is_empty || (!bus.stall && (is_half || (is_full && !conflict))));
    assign accept   = bus.pair_valid && ready;
    assign bus.pair_ready = ready;

    always_comb begin
        state_d  = state_q;
        even_d   = NOP_EVEN;
        odd_d    = NOP_ODD;
        even_v_d = 1'b0;
        odd_v_d  = 1'b0;
        if (bus.flush) begin
            state_d = ISSUE_EMPTY;
        end else begin
            if (advance && is_full) begin
                if (buf_q.pipe1) begin
                    odd_d = buf_q.instr1;  odd_v_d = 1'b1;
                end else begin
                    even_d = buf_q.instr1; even_v_d = 1'b1;
                end
                state_d = conflict ? ISSUE_HALF : ISSUE_EMPTY;
            end
            // the second instruction goes out now when the pair is clean, or on the split's second cycle
            if (advance && ((is_full && !conflict) || is_half)) begin
                if (buf_q.pipe2) begin
                    odd_d = buf_q.instr2;  odd_v_d = 1'b1;
                end else begin
                    even_d = buf_q.instr2; even_v_d = 1'b1;
                end
                if (is_half) state_d = ISSUE_EMPTY;
            end
            if (accept) state_d = ISSUE_FULL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ISSUE_EMPTY;
            buf_q    <= '0;
            even_q   <= NOP_EVEN;
            odd_q    <= NOP_ODD;
            even_v_q <= 1'b0;
            odd_v_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            if (accept) buf_q <= pair_in;
            even_q   <= even_d;
            odd_q    <= odd_d;
            even_v_q <= even_v_d;
            odd_v_q  <= odd_v_d;
        end
    end

    assign bus.issue_even_instr = even_q;
    assign bus.issue_odd_instr  = odd_q;
    assign bus.issue_even_valid = even_v_q;
    assign bus.issue_odd_valid  = odd_v_q;

`ifdef ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_dual  <= '0;
            stat_split <= '0;
            stat_stall <= '0;
        end else begin
            if (advance && is_full && !conflict) stat_dual  <= sat_inc(stat_dual);
            if (advance && is_full && conflict)  stat_split <= sat_inc(stat_split);
            if (!bus.flush && bus.stall && !is_empty) stat_stall <= sat_inc(stat_stall);
        end
    end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb/tb_dual_issue_scheduler.sv - directed and random checks of dual_issue_scheduler against an issue-queue model
module tb_dual_issue_scheduler;
    import dual_issue_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dual_issue_scheduler_if bus ();

`ifdef ISSUE_STATS_EN
    logic [31:0] stat_dual, stat_split, stat_stall;
`endif

    dual_issue_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave)
`ifdef ISSUE_STATS_EN
        ,
        .stat_dual  (stat_dual),
        .stat_split (stat_split),
        .stat_stall (stat_stall)
`endif
    );

    // one entry per issue cycle the buffered pair still needs
    typedef struct {
        logic [31:0] ei;
        logic        ev;
        logic [31:0] oi;
        logic        ov;
        int          kind;   // 1: dual-issue pair, 2: first half of a split, 0: otherwise
    } op_t;

    op_t q[$];
    op_t exp_out;
    int  errors = 0;
    int  checks = 0;
    int  m_dual = 0, m_split = 0, m_stall = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_conflict(input bit p1, input bit p2, input logic [6:0] dst,
                                        input bit wr, input logic [20:0] src, input logic [2:0] sv);
        if (p1 == p2) return 1'b1;
        if (!wr) return 1'b0;
        for (int k = 0; k < 3; k++)
            if (sv[k] && src[k*7 +: 7] == dst) return 1'b1;
        return 1'b0;
    endfunction

    function automatic op_t nop_op();
        op_t o;
        o.ei = NOP_EVEN; o.ev = 1'b0; o.oi = NOP_ODD; o.ov = 1'b0; o.kind = 0;
        return o;
    endfunction

    function automatic op_t put(input op_t o, input bit pipe, input logic [31:0] ins);
        op_t r = o;
        if (pipe) begin r.oi = ins; r.ov = 1'b1; end
        else      begin r.ei = ins; r.ev = 1'b1; end
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".even_instr"}, bus.issue_even_instr, exp_out.ei);
        chk({tag, ".even_valid"}, {31'd0, bus.issue_even_valid}, {31'd0, exp_out.ev});
        chk({tag, ".odd_instr"},  bus.issue_odd_instr,  exp_out.oi);
        chk({tag, ".odd_valid"},  {31'd0, bus.issue_odd_valid},  {31'd0, exp_out.ov});
    endtask

    task automatic step(input string tag, input bit v, input logic [31:0] i1, input logic [31:0] i2,
                        input bit p1, input bit p2, input logic [6:0] dst, input bit wr,
                        input logic [20:0] src, input logic [2:0] sv, input bit st, input bit fl);
        bit exp_ready;
        op_t a;
        @(negedge clk);
        bus.pair_valid = v;  bus.pair_instr1 = i1; bus.pair_instr2 = i2;
        bus.pair_pipe1 = p1; bus.pair_pipe2 = p2;  bus.pair_dst1 = dst;
        bus.pair_wr1 = wr;   bus.pair_src2 = src;  bus.pair_src2_v = sv;
        bus.stall = st;      bus.flush = fl;
        #1;
        exp_ready = !fl && (q.size() == 0 || (!st && q.size() == 1));
        chk({tag, ".pair_ready"}, {31'd0, bus.pair_ready}, {31'd0, exp_ready});
        exp_out = nop_op();
        if (fl) q.delete();
        else begin
            if (st && q.size() > 0) m_stall++;
            if (!st && q.size() > 0) begin
                exp_out = q.pop_front();
                if (exp_out.kind == 1) m_dual++;
                if (exp_out.kind == 2) m_split++;
            end
            if (v && exp_ready) begin
                if (ref_conflict(p1, p2, dst, wr, src, sv)) begin
                    a = put(nop_op(), p1, i1); a.kind = 2; q.push_back(a);
                    a = put(nop_op(), p2, i2); q.push_back(a);
                end else begin
                    a = put(put(nop_op(), p1, i1), p2, i2); a.kind = 1; q.push_back(a);
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n, input bit st);
        for (int i = 0; i < n; i++) step(tag, 1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b0, '0, '0, st, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        bus.pair_valid = 1'b0; bus.pair_instr1 = '0; bus.pair_instr2 = '0;
        bus.pair_pipe1 = 1'b0; bus.pair_pipe2 = 1'b1; bus.pair_dst1 = '0;
        bus.pair_wr1 = 1'b0;   bus.pair_src2 = '0;   bus.pair_src2_v = '0;
        bus.stall = 1'b0;      bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_out = nop_op();
        check_outputs("reset");
        chk("reset.pair_ready", {31'd0, bus.pair_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // dual pairs back to back: even add, odd lqd
        step("dual0", 1, 32'h18040203, 32'h34000285, 0, 1, 7'd3, 1, 21'd0, 3'b000, 0, 0);
        step("dual1", 1, 32'h18111111, 32'h34222222, 1, 0, 7'd9, 1, {7'd9, 7'd0, 7'd0}, 3'b000, 0, 0);
        step("dual2", 1, 32'h18333333, 32'h34444444, 0, 1, 7'd1, 0, {7'd1, 7'd1, 7'd1}, 3'b111, 0, 0);
        idle("drain", 2, 0);

        // both even: split
        step("even2", 1, 32'h18555555, 32'h18666666, 0, 0, 7'd2, 0, 21'd0, 3'b000, 0, 0);
        step("even2b", 1, 32'h18777777, 32'h34888888, 0, 1, 7'd2, 0, 21'd0, 3'b000, 0, 0);
        idle("drain", 3, 0);

        // instr1 writes r5, instr2 rb = r5: split with rb valid, dual without
        step("raw", 1, 32'h18aaaaaa, 32'h34bbbbbb, 0, 1, 7'd5, 1, {7'd1, 7'd5, 7'd2}, 3'b010, 0, 0);
        idle("raw", 2, 0);
        step("norb", 1, 32'h18cccccc, 32'h34dddddd, 0, 1, 7'd5, 1, {7'd1, 7'd5, 7'd2}, 3'b101, 0, 0);
        idle("norb", 2, 0);

        // three stalls while instr2 is pending
        step("hstall", 1, 32'h34eeeeee, 32'h34ffffff, 1, 1, 7'd0, 0, 21'd0, 3'b000, 0, 0);
        idle("hstall_a", 1, 0);
        idle("hstall_s", 3, 1);
        idle("hstall_r", 2, 0);

        // flush together with stall discards a full buffer
        step("fl_load", 1, 32'h18121212, 32'h34343434, 0, 1, 7'd0, 0, 21'd0, 3'b000, 0, 0);
        step("fl_go", 0, '0, '0, 0, 1, '0, 0, '0, '0, 1, 1);
        idle("fl_after", 2, 0);

        // reset in the middle of a split clears outputs without a clock
        step("mid", 1, 32'h18565656, 32'h18787878, 0, 0, 7'd0, 0, 21'd0, 3'b000, 0, 0);
        idle("mid_a", 1, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        q.delete();
        m_dual = 0; m_split = 0; m_stall = 0;
        exp_out = nop_op();
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
        idle("post_rst", 2, 0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] r1, r2;
            logic [6:0]  rd;
            logic [20:0] rs;
            r1 = $urandom();
            r2 = $urandom();
            rd = 7'($urandom_range(0, 7));
            rs = {7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7))};
            step("rand", ($urandom_range(0, 9) < 8), r1, r2, 1'($urandom()), 1'($urandom()), rd,
                 1'($urandom()), rs, 3'($urandom()), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 19) == 0));
        end
        idle("final", 3, 0);

`ifdef ISSUE_STATS_EN
        chk("stat_dual",  stat_dual,  32'(m_dual));
        chk("stat_split", stat_split, 32'(m_split));
        chk("stat_stall", stat_stall, 32'(m_stall));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
